// File: rtl/arb_pkg.sv
// arb_pkg: shared types and helpers for the round-robin memory arbiter.
package arb_pkg;
  typedef enum logic {IDLE, OWN} state_t;
  // Index width that stays legal (>=1 bit) even for single-entry vectors.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
  localparam int MAX_CORES = 8;
  localparam int ID_W = clog2_min1(MAX_CORES);
endpackage

// File: rtl/rr_pick.sv
// rr_pick: first set request at or after start, searching upward with wrap-around.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic         found,
  output logic [W-1:0] idx
);
  int k;
  // Walk offsets from farthest to nearest so the nearest hit is the last one written.
  always_comb begin
    found = |req;
    idx = '0;
    k = 0;
    for (int i = N - 1; i >= 0; i--) begin
      k = (int'(start) + i) % N;
      if (req[W'(k)]) idx = W'(k);
    end
  end
endmodule

// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr: round-robin N-core arbiter onto one data memory port with
// a hold cap and tag-routed read return across the RAM read latency.
module mem_arbiter_rr
  import arb_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int MAX_HOLD = 8,
  parameter int RD_LAT = 0,
  localparam int IW = clog2_min1(NUM_CORES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  input  logic [NUM_CORES-1:0]        core_memwrite,
  input  logic [NUM_CORES-1:0]        core_memread,
  output logic [NUM_CORES-1:0]        core_grant,
  output logic [NUM_CORES*DATA_W-1:0] core_rdata,
  output logic [NUM_CORES-1:0]        core_rvalid,
  output logic [ADDR_W-1:0]           ram_addr,
  output logic [DATA_W-1:0]           ram_wdata,
  output logic                        ram_memwrite,
  output logic                        ram_memread,
  input  logic [DATA_W-1:0]           ram_rdata,
  output logic [IW-1:0]               owner_id,
  output logic                        busy
);
  localparam int HW = clog2_min1(MAX_HOLD);
  state_t r_state, w_state;
  logic [IW-1:0] r_owner, w_owner, r_ptr, w_ptr, w_pick, w_a_idx, w_b_idx, w_tid;
  logic [HW-1:0] r_hold, w_hold;
  logic [NUM_CORES-1:0] w_own_oh;
  logic w_a_found, w_b_found, w_own_req, w_new, w_tv;
  assign w_own_oh = NUM_CORES'(1) << r_owner;
  assign w_own_req = core_req[r_owner];
  assign busy = r_state == OWN;
  assign owner_id = r_owner;
  assign core_grant = busy ? w_own_oh : '0;
  rr_pick #(.N(NUM_CORES), .W(IW)) u_pick_any (
    .req(core_req), .start(r_ptr), .found(w_a_found), .idx(w_a_idx)
  );
  // Forced rotation must skip the current owner even though it is still requesting.
  rr_pick #(.N(NUM_CORES), .W(IW)) u_pick_rot (
    .req(core_req & ~w_own_oh), .start(r_ptr), .found(w_b_found), .idx(w_b_idx)
  );
  always_comb begin
    w_state = r_state;
    w_owner = r_owner;
    w_hold = r_hold;
    w_ptr = r_ptr;
    w_new = 1'b0;
    w_pick = w_a_idx;
    if (r_state == IDLE || !w_own_req) begin
      w_state = w_a_found ? OWN : IDLE;
      w_new = w_a_found;
    end else if (r_hold == HW'(MAX_HOLD - 1) && w_b_found) begin
      w_new = 1'b1;
      w_pick = w_b_idx;
    end else begin
      w_hold = (r_hold == HW'(MAX_HOLD - 1)) ? r_hold : r_hold + 1'b1;
    end
    if (w_new) begin
      w_owner = w_pick;
      w_hold = '0;
      w_ptr = (w_pick == IW'(NUM_CORES - 1)) ? '0 : w_pick + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_hold <= '0;
      r_ptr <= '0;
    end else begin
      r_state <= w_state;
      r_owner <= w_owner;
      r_hold <= w_hold;
      r_ptr <= w_ptr;
    end
  end
  always_comb begin
    ram_addr = '0;
    ram_wdata = '0;
    ram_memwrite = 1'b0;
    ram_memread = 1'b0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (busy && r_owner == IW'(i)) begin
        ram_addr = core_addr[i*ADDR_W +: ADDR_W];
        ram_wdata = core_wdata[i*DATA_W +: DATA_W];
        ram_memwrite = core_req[i] & core_memwrite[i];
        ram_memread = core_req[i] & core_memread[i];
      end
    end
  end
  generate
    if (RD_LAT == 0) begin : g_comb
      assign w_tv = ram_memread;
      assign w_tid = r_owner;
    end else begin : g_pipe
      logic [RD_LAT-1:0] r_tv;
      logic [RD_LAT-1:0][IW-1:0] r_tid;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_tv <= '0;
          r_tid <= '0;
        end else begin
          r_tv[0] <= ram_memread;
          r_tid[0] <= r_owner;
          for (int i = 1; i < RD_LAT; i++) begin
            r_tv[i] <= r_tv[i-1];
            r_tid[i] <= r_tid[i-1];
          end
        end
      end
      assign w_tv = r_tv[RD_LAT-1];
      assign w_tid = r_tid[RD_LAT-1];
    end
  endgenerate
  // Return is steered by the tag, not the live owner, so late data follows its requester.
  always_comb begin
    core_rvalid = '0;
    core_rdata = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (w_tv && w_tid == IW'(i)) begin
        core_rvalid[i] = 1'b1;
        core_rdata[i*DATA_W +: DATA_W] = ram_rdata;
      end
    end
  end
endmodule
